// File: rtl/result_trace.sv
// result_trace: debug trace buffer for the processor result/zero outputs.
// Arms on command, triggers on the first zero flag, then records every change
// of {zero,result} into a small FIFO that the host drains with registered reads.
module result_trace #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        result,
    input  logic              zero,
    input  logic              arm,
    input  logic              stop,
    input  logic              rd_req,
    output logic [8:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        zero_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [8:0]          last_q, last_d;
    logic                first_q, first_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          zeroCount_q, zeroCount_d;
    logic [8:0]          rdData_q, rdData_d;
    logic                rdValid_q, rdValid_d;
    logic [8:0]          mem_q [DEPTH];

    logic [8:0]          sample;
    logic                isFull;
    logic                isEmpty;
    logic                rdFire;
    logic                wrAttempt;
    logic                wrAccept;
    logic                wrDrop;
    logic                armStart;

    assign sample  = {zero, result};
    assign isFull  = (count_q == FULL_COUNT);
    assign isEmpty = (count_q == '0);
    assign rdFire  = rd_req && !isEmpty;

    // Decide whether this cycle attempts a write, and whether it lands or is dropped.
    // A full FIFO still accepts the write when a read frees the head slot in the same cycle.
    always_comb begin
        wrAttempt = 1'b0;
        case (state_q)
            ARMED:   wrAttempt = zero && !stop;
            CAPTURE: wrAttempt = !stop && (first_q || (sample != last_q));
            default: wrAttempt = 1'b0;
        endcase
        wrAccept = wrAttempt && (!isFull || rdFire);
        wrDrop   = wrAttempt && isFull && !rdFire;
        armStart = (state_q == IDLE) && arm && !stop;
    end

    // Next-state computation for the trace FSM, FIFO bookkeeping and status flags.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        last_d      = last_q;
        first_d     = first_q;
        overflow_d  = overflow_q;
        zeroCount_d = zeroCount_q;
        rdData_d    = rdData_q;
        rdValid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (armStart) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (zero) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (armStart) begin
            first_d     = 1'b1;
            overflow_d  = 1'b0;
            zeroCount_d = '0;
        end

        if (wrAttempt) begin
            last_d  = sample;
            first_d = 1'b0;
        end

        if (wrDrop) begin
            overflow_d = 1'b1;
        end

        if (wrAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
            if (zero && (zeroCount_q != 8'hFF)) begin
                zeroCount_d = zeroCount_q + 8'd1;
            end
        end

        if (rdFire) begin
            rdPtr_d   = rdPtr_q + 1'b1;
            rdData_d  = mem_q[rdPtr_q];
            rdValid_d = 1'b1;
        end

        case ({wrAccept, rdFire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Register all control state; reset discards the trace and returns to IDLE at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            last_q      <= '0;
            first_q     <= 1'b1;
            overflow_q  <= 1'b0;
            zeroCount_q <= '0;
            rdData_q    <= '0;
            rdValid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            last_q      <= last_d;
            first_q     <= first_d;
            overflow_q  <= overflow_d;
            zeroCount_q <= zeroCount_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
        end
    end

    // Storage array; contents are meaningless once pointers and count are reset.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= sample;
        end
    end

    assign rd_data    = rdData_q;
    assign rd_valid   = rdValid_q;
    assign empty      = isEmpty;
    assign full       = isFull;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign zero_count = zeroCount_q;
    assign state      = state_q;

endmodule

// File: tb/tb_result_trace.sv
// Directed testbench for result_trace with hand-computed expectations.
module tb_result_trace;

    logic        clk;
    logic        reset;
    logic [7:0]  result;
    logic        zero;
    logic        arm;
    logic        stop;
    logic        rd_req;
    logic [8:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  zero_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    result_trace #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .result     (result),
        .zero       (zero),
        .arm        (arm),
        .stop       (stop),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .zero_count (zero_count),
        .state      (state)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic z,
                                 input logic a, input logic s, input logic rq);
        result = r;
        zero   = z;
        arm    = a;
        stop   = s;
        rd_req = rq;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence covering reset, trigger, reads, overflow, priority and async reset.
    initial begin
        reset = 1'b1;
        applyStimulus(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_state",    16'(state),      16'h0);
        checkOutput("rst_count",    16'(count),      16'h0);
        checkOutput("rst_empty",    16'(empty),      16'h1);
        checkOutput("rst_full",     16'(full),       16'h0);
        checkOutput("rst_overflow", 16'(overflow),   16'h0);
        checkOutput("rst_zcount",   16'(zero_count), 16'h0);
        checkOutput("rst_rdvalid",  16'(rd_valid),   16'h0);
        checkOutput("rst_rddata",   16'(rd_data),    16'h0);

        reset = 1'b0;
        tick();
        tick();
        checkOutput("idle_hold_state", 16'(state), 16'h0);
        checkOutput("idle_hold_count", 16'(count), 16'h0);

        $display("[TB] arm, trigger and change detection");
        applyStimulus(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("arm_state", 16'(state), 16'h1);
        applyStimulus(8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("pretrig_count", 16'(count), 16'h0);
        checkOutput("pretrig_state", 16'(state), 16'h1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("trig_state",  16'(state),      16'h2);
        checkOutput("trig_count",  16'(count),      16'h1);
        checkOutput("trig_zcount", 16'(zero_count), 16'h1);
        tick();
        checkOutput("dup_count", 16'(count), 16'h1);
        applyStimulus(8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("chg07_count", 16'(count), 16'h2);
        applyStimulus(8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("chg09_count",  16'(count),      16'h3);
        checkOutput("chg09_zcount", 16'(zero_count), 16'h1);

        $display("[TB] read handshake");
        rd_req = 1'b1;
        tick();
        checkOutput("rd0_valid", 16'(rd_valid), 16'h1);
        checkOutput("rd0_data",  16'(rd_data),  16'h100);
        checkOutput("rd0_count", 16'(count),    16'h2);
        tick();
        checkOutput("rd1_valid", 16'(rd_valid), 16'h1);
        checkOutput("rd1_data",  16'(rd_data),  16'h007);
        tick();
        checkOutput("rd2_valid", 16'(rd_valid), 16'h1);
        checkOutput("rd2_data",  16'(rd_data),  16'h009);
        checkOutput("rd2_count", 16'(count),    16'h0);
        checkOutput("rd2_empty", 16'(empty),    16'h1);
        tick();
        checkOutput("rd3_valid", 16'(rd_valid), 16'h0);
        checkOutput("rd3_count", 16'(count),    16'h0);
        rd_req = 1'b0;

        $display("[TB] overflow");
        applyStimulus(8'h09, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("stop_state", 16'(state), 16'h0);
        applyStimulus(8'h09, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("rearm_state", 16'(state), 16'h1);
        applyStimulus(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ovf_trig_count", 16'(count), 16'h1);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("ovf_full",      16'(full),     16'h1);
        checkOutput("ovf_count8",    16'(count),    16'h8);
        checkOutput("ovf_not_yet",   16'(overflow), 16'h0);
        applyStimulus(8'h18, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ovf_set",       16'(overflow), 16'h1);
        checkOutput("ovf_count_hold", 16'(count),   16'h8);
        applyStimulus(8'h19, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(8'h1A, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ovf_sticky",    16'(overflow),   16'h1);
        checkOutput("ovf_zcount",    16'(zero_count), 16'h1);

        $display("[TB] full with simultaneous read and write");
        applyStimulus(8'h1B, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("rw_valid",    16'(rd_valid), 16'h1);
        checkOutput("rw_data",     16'(rd_data),  16'h110);
        checkOutput("rw_count",    16'(count),    16'h8);
        checkOutput("rw_overflow", 16'(overflow), 16'h1);

        $display("[TB] stop/arm priority");
        applyStimulus(8'h1B, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("armstop_state", 16'(state), 16'h0);
        checkOutput("armstop_count", 16'(count), 16'h8);

        applyStimulus(8'h1B, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("drain_valid", 16'(rd_valid), 16'h1);
            checkOutput("drain_data",  16'(rd_data),
                        (i < 7) ? 16'(16'h011 + i) : 16'h01B);
        end
        tick();
        checkOutput("drain_end_valid", 16'(rd_valid), 16'h0);
        checkOutput("drain_end_count", 16'(count),    16'h0);
        rd_req = 1'b0;

        $display("[TB] asynchronous reset mid-capture");
        applyStimulus(8'h1B, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("arm2_overflow_clr", 16'(overflow),   16'h0);
        checkOutput("arm2_zcount_clr",   16'(zero_count), 16'h0);
        applyStimulus(8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("pre_rst_count", 16'(count), 16'h5);
        checkOutput("pre_rst_state", 16'(state), 16'h2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_count", 16'(count), 16'h0);
        checkOutput("async_rst_state", 16'(state), 16'h0);
        checkOutput("async_rst_empty", 16'(empty), 16'h1);
        tick();
        reset = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_state", 16'(state), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
